blowfish_multilane_engine: RTL
==============================

# blowfish_multilane_engine

Parametrised multi-lane Blowfish datapath that encrypts or decrypts LANES independent 64-bit blocks in parallel, one Feistel round per clock. Subkeys (P-array, S-boxes) are produced by the upstream key-schedule controller and loaded through a write port, so the engine holds no key-expansion logic. It supersedes the fixed two-lane 128-bit wrapper: lane count is configurable, mode is latched per block, and a valid/ready handshake with back-pressure is added. LANES=2 gives the existing 128-bit block width.

## Interface
- LANES, 2, number of parallel 64-bit lanes (1..8); data width DW = 64*LANES
- clk  in  1  rising-edge clock, only clock
- rst  in  1  reset, synchronous and active-low
- p_we  in  1  P-array write strobe
- p_addr  in  5  P index 0..17; 18..31 ignored
- p_wdata  in  32  P word
- sb_we  in  1  S-box write strobe
- sb_sel  in  2  S-box select S0..S3
- sb_addr  in  8  S-box entry
- sb_wdata  in  32  S-box word
- in_valid  in  1  input block valid
- in_ready  out  1  engine can accept
- in_mode  in  1  0 = encrypt, 1 = decrypt; sampled at accept
- in_data  in  DW  lane i = in_data[64i+63:64i], L = upper 32 bits of lane
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts result
- out_data  out  DW  result, same lane mapping
- busy  out  1  state != IDLE

## Operation
- One shared P-array (18x32) and four S-boxes (256x32, async read), replicated read ports per lane. Memories are not reset. Writes take effect only in IDLE and are dropped silently otherwise.
- F(x) = ((S0[x[31:24]] + S1[x[23:16]]) ^ S2[x[15:8]]) + S3[x[7:0]]. Additions are mod 2^32.
- Round r (r = 0..15): L ^= K(r); R ^= F(L); swap L,R. Encrypt: K(r) = P[r]. Decrypt: K(r) = P[17-r].
- After round 15: undo the swap. Encrypt: R ^= P[16], L ^= P[17]. Decrypt: R ^= P[1], L ^= P[0]. Output lane = {L,R}.
- FSM states:
  - IDLE: in_ready=1. Accept (in_valid & in_ready) latches data and mode, sets rnd=0, goes to RUN.
  - RUN: one round per cycle on all lanes. At rnd=15 the round and output whitening are both applied on that edge; the result is registered into out_data, out_valid is set, and the FSM goes to DONE.
  - DONE: out_valid held and out_data stable until out_ready.
    - out_ready & ~in_valid: go to IDLE.
    - out_ready & in_valid: in_ready=1 in this state and cycle, so the new block is accepted on the same edge and the FSM goes straight to RUN. This gives back-to-back throughput of one block per 17 cycles.
- in_ready = (state==IDLE) | (state==DONE & out_ready). in_ready is 0 while rst=0.
- rnd is a 4-bit counter with no wrap beyond 15.

## Timing
- Reset (rst=0 at an edge): state=IDLE, rnd=0, out_valid=0, out_data=0, busy=0. Reset during RUN or DONE aborts the block; no output is produced. P and S contents are kept.
- Latency: accept at edge k gives out_valid=1 after edge k+16, i.e. 16 RUN cycles. The first cycle with out_valid high is cycle k+17.
- out_data changes only on the edge that sets out_valid. It is otherwise stable.
- in_mode and in_data are don't-care when not accepted.
- Table writes issued in the same cycle as an accept from IDLE take effect. The first RUN round sees the new values.

## Test plan
- P=0, S=0, LANES=2, encrypt 0x0123456789ABCDEF_FEDCBA9876543210 -> out_data 0x89ABCDEF01234567_76543210FEDCBA98, out_valid at cycle +17.
- P=0 except P[17]=0xFFFFFFFF, S=0. Encrypt lane {a,b} -> {~b,a}. Decrypt {~b,a} -> {a,b}. Use a=0x11111111, b=0x22222222: expect 0xDDDDDDDD11111111, then round-trip back to 0x1111111122222222.
- Tables generated by the golden software key schedule for an all-zero key, pt=0 on every lane -> every lane 0x4EF997456198DD78. Decrypt of that value returns 0 on every lane.
- Back-pressure: hold out_ready=0 for 10 cycles. out_data is stable, in_ready=0. Raise out_ready with in_valid=1: the next block is accepted the same cycle, and its result appears 17 cycles later.
- Reset mid-RUN at rnd=7 -> out_valid stays 0, busy=0. A new accept afterwards gives a correct result with the previously loaded tables retained.
- p_we/sb_we pulsed during RUN with garbage -> ignored. The result matches the golden model, and a subsequent IDLE write is honoured.

Source files
------------

// File: rtl/blowfish_multilane_engine.sv
// Multi-lane Blowfish round engine: LANES independent 64-bit blocks advance one
// Feistel round per clock against externally loaded P-array and S-box tables.
module blowfish_multilane_engine #(
  parameter  int LANES = 2,
  localparam int DW    = 64 * LANES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p_we,
  input  logic [4:0]    p_addr,
  input  logic [31:0]   p_wdata,
  input  logic          sb_we,
  input  logic [1:0]    sb_sel,
  input  logic [7:0]    sb_addr,
  input  logic [31:0]   sb_wdata,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_mode,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  logic [3:0]    rnd_q;
  logic          mode_q;
  logic [31:0]   l_q [LANES];
  logic [31:0]   r_q [LANES];
  logic [31:0]   l_d [LANES];
  logic [31:0]   r_d [LANES];
  logic [DW-1:0] res_d;
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;

  logic [31:0] p_q  [18];
  logic [31:0] s0_q [256];
  logic [31:0] s1_q [256];
  logic [31:0] s2_q [256];
  logic [31:0] s3_q [256];

  // NOTE: key tables carry no reset; their contents must survive a datapath
  // reset, and resetting large arrays would also block RAM inference.
  always_ff @(posedge clk) begin
    if (p_we && state_q == IDLE && p_addr < 5'd18)
      p_q[p_addr] <= p_wdata;
    if (sb_we && state_q == IDLE) begin
      case (sb_sel)
        2'd0:    s0_q[sb_addr] <= sb_wdata;
        2'd1:    s1_q[sb_addr] <= sb_wdata;
        2'd2:    s2_q[sb_addr] <= sb_wdata;
        default: s3_q[sb_addr] <= sb_wdata;
      endcase
    end
  end

  // Decryption walks the P-array backwards, including the output whitening pair.
  logic [4:0]  k_idx;
  logic [31:0] k_w, wl_w, wr_w;
  assign k_idx = mode_q ? 5'(5'd17 - {1'b0, rnd_q}) : {1'b0, rnd_q};
  assign k_w   = p_q[k_idx];
  assign wl_w  = mode_q ? p_q[0] : p_q[17];
  assign wr_w  = mode_q ? p_q[1] : p_q[16];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [31:0] lx, fx, rx;
    assign lx = l_q[g] ^ k_w;
    assign fx = ((s0_q[lx[31:24]] + s1_q[lx[23:16]]) ^ s2_q[lx[15:8]]) + s3_q[lx[7:0]];
    assign rx = r_q[g] ^ fx;
    assign l_d[g] = rx;
    assign r_d[g] = lx;
    // Final round: the swap is undone, so lx stays on the left.
    assign res_d[64*g +: 64] = {lx ^ wl_w, rx ^ wr_w};
  end

  assign in_ready  = rst & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      rnd_q       <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < LANES; i++) begin
        l_q[i] <= '0;
        r_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q <= RUN;
            rnd_q   <= '0;
            mode_q  <= in_mode;
            for (int i = 0; i < LANES; i++) begin
              l_q[i] <= in_data[64*i+32 +: 32];
              r_q[i] <= in_data[64*i +: 32];
            end
          end
        end
        RUN: begin
          for (int i = 0; i < LANES; i++) begin
            l_q[i] <= l_d[i];
            r_q[i] <= r_d[i];
          end
          if (rnd_q == 4'd15) begin
            out_data_q  <= res_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              state_q <= RUN;
              rnd_q   <= '0;
              mode_q  <= in_mode;
              for (int i = 0; i < LANES; i++) begin
                l_q[i] <= in_data[64*i+32 +: 32];
                r_q[i] <= in_data[64*i +: 32];
              end
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
